// File: rtl/div32by16_seq.sv
// -----------------------------------------------------------------------------
// div32by16_seq
// Sequential 32-by-16 unsigned restoring divider. Resolves one quotient bit
// per clock under a start/busy/done handshake. Designed as the inverse of the
// 16x16 multiplier: dividend == quotient*divisor + remainder.
//
// Configuration macro: DIV32BY16_FAST_EXC_EN
//   defined   - zero-divisor / overflow starts take a one-cycle EXC state and
//               report at E1.
//   undefined - exception starts run the full 16 iterations; the datapath
//               result is discarded and the exception result is loaded at E16.
//   Result values and flags are identical in both builds.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request, accepted in IDLE or DONE
//   dividend     in  32   captured on accepted start
//   divisor      in  16   captured on accepted start
//   quotient     out 16   registered result, held until next DONE
//   remainder    out 16   registered result, held until next DONE
//   busy         out  1   high while RUN (and EXC)
//   done         out  1   one-cycle pulse when results update
//   div_by_zero  out  1   result flag, held with the result
//   overflow     out  1   result flag, held with the result
// -----------------------------------------------------------------------------
module div32by16_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic        overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
`ifdef DIV32BY16_FAST_EXC_EN
      ST_EXC  = 2'd3,
`endif
      ST_DONE = 2'd2
   } state_t;

   state_t      state_r;

   // Partial remainder. Always stays below the divisor while running, so its
   // 17th bit is constant zero and is not stored.
   logic [15:0] pr_r;
   logic [15:0] qs_r;      // dividend low half shifting out, quotient in
   logic [15:0] d_r;       // captured divisor
   logic [15:0] hi_r;      // captured dividend[31:16] for the exception result
   logic [3:0]  cnt_r;     // iteration counter
   logic        dbz_r;     // captured zero-divisor condition
   logic        ovf_r;     // captured overflow condition

   logic [16:0] t_s;
   logic        ge_s;
   logic [15:0] diff_s;
   logic [15:0] pr_nxt_s;
   logic [15:0] qs_nxt_s;
   logic        dbz_s;
   logic        ovf_s;

   // One restoring iteration plus exception detection on the live inputs.
   always_comb begin
      t_s      = {pr_r, qs_r[15]};
      ge_s     = (t_s >= {1'b0, d_r});
      // Only the low 16 bits of t - d are needed: the difference is below d.
      diff_s   = t_s[15:0] - d_r;
      pr_nxt_s = t_s[15:0];
      qs_nxt_s = {qs_r[14:0], ge_s};
      if (ge_s) begin
         pr_nxt_s = diff_s;
      end else begin
         pr_nxt_s = t_s[15:0];
      end
      dbz_s = (divisor == 16'd0);
      if (divisor == 16'd0) begin
         ovf_s = 1'b0;
      end else begin
         ovf_s = (dividend[31:16] >= divisor);
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pr_r        <= 16'd0;
         qs_r        <= 16'd0;
         d_r         <= 16'd0;
         hi_r        <= 16'd0;
         cnt_r       <= 4'd0;
         dbz_r       <= 1'b0;
         ovf_r       <= 1'b0;
         quotient    <= 16'd0;
         remainder   <= 16'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  pr_r  <= dividend[31:16];
                  qs_r  <= dividend[15:0];
                  d_r   <= divisor;
                  hi_r  <= dividend[31:16];
                  cnt_r <= 4'd0;
                  dbz_r <= dbz_s;
                  ovf_r <= ovf_s;
                  busy  <= 1'b1;
`ifdef DIV32BY16_FAST_EXC_EN
                  if (dbz_s || ovf_s) begin
                     state_r <= ST_EXC;
                  end else begin
                     state_r <= ST_RUN;
                  end
`else
                  state_r <= ST_RUN;
`endif
               end else begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               pr_r  <= pr_nxt_s;
               qs_r  <= qs_nxt_s;
               cnt_r <= cnt_r + 4'd1;
               if (cnt_r == 4'd15) begin
                  // Last iteration: publish from the next-state values.
                  state_r     <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  div_by_zero <= dbz_r;
                  overflow    <= ovf_r;
                  if (dbz_r || ovf_r) begin
                     quotient  <= 16'hFFFF;
                     remainder <= hi_r;
                  end else begin
                     quotient  <= qs_nxt_s;
                     remainder <= pr_nxt_s;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
`ifdef DIV32BY16_FAST_EXC_EN
            ST_EXC: begin
               state_r     <= ST_DONE;
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= dbz_r;
               overflow    <= ovf_r;
               quotient    <= 16'hFFFF;
               remainder   <= hi_r;
            end
`endif
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div32by16_seq.sv
// -----------------------------------------------------------------------------
// tb_div32by16_seq
// Self-checking bench for div32by16_seq. Expected results come from plain
// integer division of the operands; exception results and latencies follow
// the block's documented rules. Honors DIV32BY16_FAST_EXC_EN for latency.
// -----------------------------------------------------------------------------
module tb_div32by16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;

`ifdef DIV32BY16_FAST_EXC_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   div32by16_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder),
      .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference: arithmetic result or exception result.
   function automatic void model(input logic [31:0] dvd, input logic [15:0] dvs,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic z, output logic o);
      logic [31:0] d32;
      d32 = {16'd0, dvs};
      if (dvs == 16'd0) begin
         q = 16'hFFFF; r = dvd[31:16]; z = 1'b1; o = 1'b0;
      end else if (dvd[31:16] >= dvs) begin
         q = 16'hFFFF; r = dvd[31:16]; z = 1'b0; o = 1'b1;
      end else begin
         q = 16'(dvd / d32); r = 16'(dvd % d32); z = 1'b0; o = 1'b0;
      end
   endfunction

   function automatic int exp_lat(input logic [31:0] dvd, input logic [15:0] dvs);
      if (FAST && (dvs == 16'd0 || dvd[31:16] >= dvs)) return 1;
      return 16;
   endfunction

   // Issue one division and wait (bounded) for done; returns busy after E0
   // and the number of edges from E0 to done.
   task automatic run_one(input logic [31:0] dvd, input logic [15:0] dvs,
                          output logic b0, output int lat);
      @(negedge clk);
      dividend = dvd; divisor = dvs; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = $urandom;           // later input changes must not matter
      divisor  = 16'($urandom);
      b0  = busy;
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 16'd0;
      #12;
      checks++;
      if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 36'd0) begin
         errors++;
         $display("FAIL reset: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, need all 0",
                  quotient, remainder, busy, done, div_by_zero, overflow);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b, need 0 0", busy, done);
      end
   endtask

   task automatic test_directed;
      logic [31:0] dv [4];
      logic [15:0] ds [4];
      logic [15:0] eq, er;
      logic ez, eo, b0;
      int lat;
      dv[0] = 32'h0000_0064; ds[0] = 16'h0007;
      dv[1] = 32'hFFFE_0001; ds[1] = 16'hFFFF;
      dv[2] = 32'h1234_5678; ds[2] = 16'h0000;
      dv[3] = 32'h0001_0000; ds[3] = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         model(dv[i], ds[i], eq, er, ez, eo);
         run_one(dv[i], ds[i], b0, lat);
         checks++;
         if (b0 !== 1'b1) begin
            errors++;
            $display("FAIL directed_busy[%0d]: got %b need 1", i, b0);
         end
         checks++;
         if (lat !== exp_lat(dv[i], ds[i])) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d need %0d", i, lat, exp_lat(dv[i], ds[i]));
         end
         checks++;
         if (quotient !== eq || remainder !== er || div_by_zero !== ez || overflow !== eo || busy !== 1'b0) begin
            errors++;
            $display("FAIL directed_result[%0d] %h/%h: got q=%h r=%h dbz=%b ovf=%b busy=%b, need q=%h r=%h dbz=%b ovf=%b busy=0",
                     i, dv[i], ds[i], quotient, remainder, div_by_zero, overflow, busy, eq, er, ez, eo);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] dvd;
      logic [15:0] dvs, hi, eq, er;
      logic ez, eo, b0;
      int lat;
      for (int i = 0; i < 288; i++) begin
         if (i < 256) begin
            dvs = 16'($urandom_range(1, 65535));
            hi  = 16'($urandom % {16'd0, dvs});
            dvd = {hi, 16'($urandom)};
         end else begin
            dvd = $urandom;
            dvs = (i % 8 == 0) ? 16'd0 : 16'($urandom);
         end
         model(dvd, dvs, eq, er, ez, eo);
         run_one(dvd, dvs, b0, lat);
         checks++;
         if (lat !== exp_lat(dvd, dvs) || quotient !== eq || remainder !== er ||
             div_by_zero !== ez || overflow !== eo) begin
            errors++;
            $display("FAIL random[%0d] %h/%h: got q=%h r=%h dbz=%b ovf=%b lat=%0d, need q=%h r=%h dbz=%b ovf=%b lat=%0d",
                     i, dvd, dvs, quotient, remainder, div_by_zero, overflow, lat,
                     eq, er, ez, eo, exp_lat(dvd, dvs));
         end
      end
   endtask

   task automatic test_start_ignored;
      logic [15:0] eq, er;
      logic ez, eo;
      int lat;
      model(32'h0000_0064, 16'h0007, eq, er, ez, eo);
      @(negedge clk);
      dividend = 32'h0000_0064; divisor = 16'h0007; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      dividend = 32'h0003_0009; divisor = 16'h0005; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 5;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 16 || quotient !== eq || remainder !== er) begin
         errors++;
         $display("FAIL start_ignored: got q=%h r=%h lat=%0d, need q=%h r=%h lat=16",
                  quotient, remainder, lat, eq, er);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored_after: done=%b busy=%b, need 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] aq, ar, bq, br;
      logic az, ao, bz, bo, b0;
      int lat;
      model(32'h0BAD_F00D, 16'h1234, aq, ar, az, ao);
      model(32'h0000_FFFF, 16'h0010, bq, br, bz, bo);
      run_one(32'h0BAD_F00D, 16'h1234, b0, lat);
      checks++;
      if (lat !== 16 || quotient !== aq || remainder !== ar) begin
         errors++;
         $display("FAIL b2b_first: got q=%h r=%h lat=%0d, need q=%h r=%h lat=16",
                  quotient, remainder, lat, aq, ar);
      end
      // Still in the DONE cycle: request the next division for E17.
      dividend = 32'h0000_FFFF; divisor = 16'h0010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || quotient !== aq || remainder !== ar) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b done=%b q=%h r=%h, need busy=1 done=0 q=%h r=%h",
                  busy, done, quotient, remainder, aq, ar);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 16 || quotient !== bq || remainder !== br || div_by_zero !== bz || overflow !== bo) begin
         errors++;
         $display("FAIL b2b_second: got q=%h r=%h lat=%0d, need q=%h r=%h lat=16",
                  quotient, remainder, lat, bq, br);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_single_cycle: got done=%b need 0", done);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] eq, er;
      logic ez, eo, b0;
      int lat, seen;
      @(negedge clk);
      dividend = 32'h00FF_1234; divisor = 16'h0321; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 36'd0) begin
         errors++;
         $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, need all 0",
                  quotient, remainder, busy, done, div_by_zero, overflow);
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_mid_abort: busy/done seen %0d cycles, need 0", seen);
      end
      model(32'h00FF_1234, 16'h0321, eq, er, ez, eo);
      run_one(32'h00FF_1234, 16'h0321, b0, lat);
      checks++;
      if (lat !== 16 || quotient !== eq || remainder !== er || div_by_zero !== ez || overflow !== eo) begin
         errors++;
         $display("FAIL reset_mid_recover: got q=%h r=%h lat=%0d, need q=%h r=%h lat=16",
                  quotient, remainder, lat, eq, er);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
